gen_gamma_encoder: RTL and testbench

Serial generalized (exp-Golomb order K) gamma encoder and the transmit-side counterpart of `gen_gamma_decoder`. It accepts one SIZE-bit unsigned value per transaction and forms the offset value M = N + 2^K on SIZE+1 bits. It then streams (L-1-K) zero prefix bits followed by the L-bit binary of M, MSB first, where L is the bit length of M. Output is one bit per accepted beat on a valid/ready bit stream. The decoder recovers N by the matching subtraction of 2^K.

---
 rtl/gen_gamma_encoder_if.sv | 25 ++
 rtl/gen_gamma_encoder.sv | 79 +++++++
 tb/tb_gen_gamma_encoder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/gen_gamma_encoder_if.sv
// rtl/gen_gamma_encoder_if.sv - value input and serial bit output bundle for gen_gamma_encoder
interface gen_gamma_encoder_if #(
  parameter int SIZE = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_data;
  logic            bit_out;
  logic            bit_valid;
  logic            bit_ready;
  logic            bit_last;
  logic            busy;

  // Upstream producer and downstream consumer side (drives values, accepts bits)
  modport master (
    output in_valid, in_data, bit_ready,
    input  in_ready, bit_out, bit_valid, bit_last, busy
  );

  // Encoder side
  modport slave (
    input  in_valid, in_data, bit_ready,
    output in_ready, bit_out, bit_valid, bit_last, busy
  );
endinterface

// File: rtl/gen_gamma_encoder.sv
// rtl/gen_gamma_encoder.sv - serial exp-Golomb order-K (generalized gamma) encoder
module gen_gamma_encoder #(
  parameter int SIZE = 8,
  parameter int K    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gen_gamma_encoder_if.slave   bus
);
  localparam int CW = $clog2(SIZE + 2);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PREFIX = 2'd1;
  localparam logic [1:0] ST_BODY   = 2'd2;

  logic [1:0]    state;
  logic [SIZE:0] m_q;
  logic [CW-1:0] pcnt;
  logic [CW-1:0] idx;

  logic [SIZE:0] m_next;
  logic [CW-1:0] msb_next;
  logic [CW-1:0] p_next;
  logic [SIZE:0] m_shift;
  logic          bit_hs;

  // Offset value for the incoming word and the index of its leading one (L-1)
  always_comb begin
    m_next   = {1'b0, bus.in_data} + ((SIZE + 1)'(1) << K);
    msb_next = '0;
    for (int i = 0; i <= SIZE; i++) begin
      if (m_next[i]) msb_next = CW'(i);
    end
    p_next   = msb_next - CW'(K);
  end

  assign m_shift       = m_q >> idx;
  assign bit_hs        = bus.bit_valid && bus.bit_ready;

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.bit_valid = (state == ST_PREFIX) || (state == ST_BODY);
  assign bus.bit_out   = (state == ST_BODY) && m_shift[0];
  assign bus.bit_last  = (state == ST_BODY) && (idx == '0);

  // Codeword sequencer: accept, emit zero prefix, then emit M from its leading one down
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      m_q   <= '0;
      pcnt  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            m_q   <= m_next;
            idx   <= msb_next;
            pcnt  <= p_next;
            state <= (p_next != '0) ? ST_PREFIX : ST_BODY;
          end
        end
        ST_PREFIX: begin
          if (bit_hs) begin
            pcnt <= pcnt - 1'b1;
            if (pcnt == CW'(1)) state <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (bit_hs) begin
            if (idx == '0) state <= ST_IDLE;
            else           idx   <= idx - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gen_gamma_encoder.sv
// tb/tb_gen_gamma_encoder.sv - directed self-checking bench for gen_gamma_encoder
module tb_gen_gamma_encoder;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  gen_gamma_encoder_if #(.SIZE(8)) if0 ();
  gen_gamma_encoder_if #(.SIZE(8)) if2 ();

  gen_gamma_encoder #(.SIZE(8), .K(0)) u_k0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  gen_gamma_encoder #(.SIZE(8), .K(2)) u_k2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"},  32'(if0.in_ready),  32'd1);
    chk({tag, " busy"},      32'(if0.busy),      32'd0);
    chk({tag, " bit_valid"}, 32'(if0.bit_valid), 32'd0);
    chk({tag, " bit_out"},   32'(if0.bit_out),   32'd0);
    chk({tag, " bit_last"},  32'(if0.bit_last),  32'd0);
  endtask

  // sel=0 drives the K=0 encoder, sel=1 the K=2 encoder; bits are listed MSB-first in the low n bits
  task automatic encode(input bit sel, input logic [7:0] data, input logic [31:0] bits, input int n,
                        input string tag);
    @(negedge clk);
    if (sel) begin if2.in_data = data; if2.in_valid = 1'b1; end
    else     begin if0.in_data = data; if0.in_valid = 1'b1; end
    @(negedge clk);
    if2.in_valid = 1'b0;
    if0.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("%s bit%0d valid", tag, i), 32'(sel ? if2.bit_valid : if0.bit_valid), 32'd1);
      chk($sformatf("%s bit%0d out", tag, i),   32'(sel ? if2.bit_out : if0.bit_out), 32'(bits[n-1-i]));
      chk($sformatf("%s bit%0d last", tag, i),  32'(sel ? if2.bit_last : if0.bit_last), 32'(i == n - 1));
      chk($sformatf("%s bit%0d busy", tag, i),  32'(sel ? if2.busy : if0.busy), 32'd1);
      chk($sformatf("%s bit%0d in_ready", tag, i), 32'(sel ? if2.in_ready : if0.in_ready), 32'd0);
    end
    @(negedge clk);
    chk({tag, " idle in_ready"},  32'(sel ? if2.in_ready : if0.in_ready), 32'd1);
    chk({tag, " idle bit_valid"}, 32'(sel ? if2.bit_valid : if0.bit_valid), 32'd0);
  endtask

  logic [7:0] rdy_pat;
  logic [4:0] exp4;
  int         ptr;

  initial begin
    rst_n         = 1'b0;
    if0.in_valid  = 1'b0;
    if0.in_data   = '0;
    if0.bit_ready = 1'b1;
    if2.in_valid  = 1'b0;
    if2.in_data   = '0;
    if2.bit_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset k2 in_ready", 32'(if2.in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    encode(1'b0, 8'd0,   32'h1,      1,  "k0 n0");
    encode(1'b0, 8'd4,   32'b00101,  5,  "k0 n4");
    encode(1'b0, 8'd255, 32'h100,    17, "k0 n255");
    encode(1'b1, 8'd0,   32'b100,    3,  "k2 n0");
    encode(1'b1, 8'd5,   32'b01001,  5,  "k2 n5");

    // Backpressure on in_data=4: bits must hold while stalled and in_data churn is ignored
    rdy_pat = 8'b1110_1001;
    exp4    = 5'b00101;
    ptr     = 0;
    @(negedge clk);
    if0.in_data  = 8'd4;
    if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("bp c%0d valid", c), 32'(if0.bit_valid), 32'd1);
      chk($sformatf("bp c%0d out", c),   32'(if0.bit_out),   32'(exp4[4-ptr]));
      chk($sformatf("bp c%0d last", c),  32'(if0.bit_last),  32'(ptr == 4));
      if0.bit_ready = rdy_pat[c];
      if0.in_data   = 8'(($urandom % 255) + 1) ^ 8'd4;
      if (rdy_pat[c]) ptr++;
      @(negedge clk);
    end
    chk("bp done in_ready", 32'(if0.in_ready), 32'd1);
    chk("bp handshakes", 32'(ptr), 32'd5);
    if0.bit_ready = 1'b1;

    // Reset during the third bit of in_data=255
    @(negedge clk);
    if0.in_data  = 8'd255;
    if0.in_valid = 1'b1;
    @(negedge clk);
    if0.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst third bit valid", 32'(if0.bit_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst async");
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst held");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst released no bits", 32'(if0.bit_valid), 32'd0);
    encode(1'b0, 8'd4, 32'b00101, 5, "post rst n4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
